// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration sequencer: writes a 7-step NTSC/PAL setting and waits for lock.
// Optional lock-wait timeout with sticky err: define PLL_CFG_LOCK_TIMEOUT_EN.
module pll_reconfig_ctrl #(
    parameter int unsigned LOCK_STABLE  = 16,
    parameter int unsigned LOCK_TIMEOUT = 1048576
) (
    input  logic        mgmt_clk,
    input  logic        mgmt_reset,
    input  logic        cfg_req,
    input  logic        cfg_sel,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, WRITE, LOCKWAIT, DONE} state_t;

    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam logic [31:0] K_NTSC = 32'd2532450157;
    localparam logic [31:0] K_PAL  = 32'd2537930535;

    state_t          state_q, state_d;
    logic [2:0]      step_q, step_d;
    logic            sel_q, sel_d;
    logic            pend_q, pend_d;
    logic            psel_q, psel_d;
    logic [2:0]      ign_q, ign_d;
    logic [SW-1:0]   stab_q, stab_d, stab_inc;
    logic [1:0]      sync_q;
    logic            locked;

`ifdef PLL_CFG_LOCK_TIMEOUT_EN
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    logic [TW-1:0]   to_q, to_d, to_inc;
    logic            err_q, err_d;
`endif

    assign locked = sync_q[1];

    // Two-flop synchronizer for the asynchronous lock indication
    always_ff @(posedge mgmt_clk) begin
        if (mgmt_reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    // State and counter registers
    always_ff @(posedge mgmt_clk) begin
        if (mgmt_reset) begin
            state_q <= IDLE;
            step_q  <= 3'd0;
            sel_q   <= 1'b0;
            pend_q  <= 1'b0;
            psel_q  <= 1'b0;
            ign_q   <= 3'd0;
            stab_q  <= '0;
`ifdef PLL_CFG_LOCK_TIMEOUT_EN
            to_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            psel_q  <= psel_d;
            ign_q   <= ign_d;
            stab_q  <= stab_d;
`ifdef PLL_CFG_LOCK_TIMEOUT_EN
            to_q    <= to_d;
            err_q   <= err_d;
`endif
        end
    end

    // Next-state: request capture, write stepping, lock qualification
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        sel_d    = sel_q;
        pend_d   = pend_q;
        psel_d   = psel_q;
        ign_d    = ign_q;
        stab_d   = stab_q;
        stab_inc = stab_q + 1'b1;
`ifdef PLL_CFG_LOCK_TIMEOUT_EN
        to_d     = to_q;
        err_d    = err_q;
        to_inc   = to_q + 1'b1;
`endif
        if (cfg_req && state_q != IDLE) begin
            pend_d = 1'b1;
            psel_d = cfg_sel;
        end
        unique case (state_q)
            IDLE: begin
                if (cfg_req || pend_q) begin
                    sel_d   = cfg_req ? cfg_sel : psel_q;
                    pend_d  = 1'b0;
                    step_d  = 3'd0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!mgmt_waitrequest) begin
                    if (step_q == 3'd6) begin
                        state_d = LOCKWAIT;
                        ign_d   = 3'd0;
                        stab_d  = '0;
`ifdef PLL_CFG_LOCK_TIMEOUT_EN
                        to_d    = '0;
`endif
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            LOCKWAIT: begin
                if (ign_q != 3'd4) begin
                    ign_d = ign_q + 3'd1;
                end else if (locked) begin
                    stab_d = stab_inc;
                    if (stab_inc == SW'(LOCK_STABLE)) begin
                        state_d = DONE;
                    end
                end else begin
                    stab_d = '0;
                end
`ifdef PLL_CFG_LOCK_TIMEOUT_EN
                to_d = to_inc;
                if (state_d != DONE && to_inc == TW'(LOCK_TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: write bus is zeroed whenever no write is presented
    always_comb begin
        mgmt_write     = (state_q == WRITE);
        busy           = (state_q == WRITE) || (state_q == LOCKWAIT);
        done           = (state_q == DONE);
        mgmt_address   = 6'h00;
        mgmt_writedata = 32'h0;
        if (mgmt_write) begin
            unique case (step_q)
                3'd0: begin mgmt_address = 6'h00; mgmt_writedata = 32'h00000000; end
                3'd1: begin mgmt_address = 6'h04; mgmt_writedata = 32'h00000404; end
                3'd2: begin mgmt_address = 6'h03; mgmt_writedata = 32'h00010000; end
                3'd3: begin mgmt_address = 6'h05; mgmt_writedata = 32'h00000404; end
                3'd4: begin mgmt_address = 6'h05; mgmt_writedata = 32'h00040202; end
                3'd5: begin mgmt_address = 6'h07; mgmt_writedata = sel_q ? K_PAL : K_NTSC; end
                3'd6: begin mgmt_address = 6'h02; mgmt_writedata = 32'h00000001; end
                default: begin mgmt_address = 6'h00; mgmt_writedata = 32'h0; end
            endcase
        end
    end

`ifdef PLL_CFG_LOCK_TIMEOUT_EN
    assign err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^LOCK_TIMEOUT;
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed testbench for pll_reconfig_ctrl.
// Define PLL_CFG_LOCK_TIMEOUT_EN to exercise the timeout build.
module tb_pll_reconfig_ctrl;
`ifdef PLL_CFG_LOCK_TIMEOUT_EN
    localparam int unsigned TO = 100;
`else
    localparam int unsigned TO = 1048576;
`endif
    localparam logic [31:0] K_NTSC = 32'd2532450157;
    localparam logic [31:0] K_PAL  = 32'd2537930535;

    logic        mgmt_clk = 1'b0;
    logic        mgmt_reset = 1'b1;
    logic        cfg_req = 1'b0;
    logic        cfg_sel = 1'b0;
    logic        mgmt_waitrequest = 1'b0;
    logic        pll_locked = 1'b1;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        busy, done, err;

    int checks = 0;
    int failures = 0;
    int stall_n = 0;
    int stall_cnt = 0;
    int glitch_at = -1;
    int lw, wcyc, stab_bad, zero_bad;
    logic        hold_v = 1'b0;
    logic [5:0]  hold_a;
    logic [31:0] hold_d;
    logic [5:0]  wr_a[$];
    logic [31:0] wr_d[$];
    logic [5:0]  exp_a[7] = '{6'h00, 6'h04, 6'h03, 6'h05, 6'h05, 6'h07, 6'h02};

    pll_reconfig_ctrl #(.LOCK_STABLE(16), .LOCK_TIMEOUT(TO)) dut (
        .mgmt_clk(mgmt_clk),
        .mgmt_reset(mgmt_reset),
        .cfg_req(cfg_req),
        .cfg_sel(cfg_sel),
        .mgmt_address(mgmt_address),
        .mgmt_write(mgmt_write),
        .mgmt_writedata(mgmt_writedata),
        .mgmt_waitrequest(mgmt_waitrequest),
        .pll_locked(pll_locked),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 mgmt_clk = ~mgmt_clk;

    // Slave model: stalls each presented write for stall_n cycles
    always @(posedge mgmt_clk) begin
        #1;
        if (mgmt_write && stall_cnt < stall_n) begin
            mgmt_waitrequest = 1'b1;
            stall_cnt++;
        end else begin
            mgmt_waitrequest = 1'b0;
            stall_cnt = 0;
        end
    end

    function automatic logic [31:0] exp_d(input int i, input logic sel);
        case (i)
            1, 3: return 32'h00000404;
            2: return 32'h00010000;
            4: return 32'h00040202;
            5: return sel ? K_PAL : K_NTSC;
            6: return 32'h00000001;
            default: return 32'h0;
        endcase
    endfunction

    task automatic clear_logs();
        wr_a.delete();
        wr_d.delete();
        lw = 0;
        wcyc = 0;
        stab_bad = 0;
        zero_bad = 0;
    endtask

    task automatic tick();
        @(negedge mgmt_clk);
        if (mgmt_write) begin
            wcyc++;
            if (hold_v && (mgmt_address !== hold_a || mgmt_writedata !== hold_d))
                stab_bad++;
            hold_v = mgmt_waitrequest;
            hold_a = mgmt_address;
            hold_d = mgmt_writedata;
            if (!mgmt_waitrequest) begin
                wr_a.push_back(mgmt_address);
                wr_d.push_back(mgmt_writedata);
            end
        end else begin
            hold_v = 1'b0;
            if (mgmt_address !== 6'h0 || mgmt_writedata !== 32'h0) zero_bad++;
        end
        if (busy && !mgmt_write) begin
            lw++;
            if (glitch_at >= 0 && lw - 1 == glitch_at) pll_locked = 1'b0;
            else if (glitch_at >= 0 && lw - 1 == glitch_at + 1) pll_locked = 1'b1;
        end
    endtask

    task automatic start(input logic sel);
        clear_logs();
        cfg_sel = sel;
        cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
        cfg_sel = 1'b0;
    endtask

    task automatic run_to_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        mgmt_reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({mgmt_write, busy, done, err} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ctl got=%b exp=0000", {mgmt_write, busy, done, err});
        end
        checks++;
        if (mgmt_address !== 6'h0 || mgmt_writedata !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus addr=%h data=%h exp=0", mgmt_address, mgmt_writedata);
        end
        mgmt_reset = 1'b0;
        clear_logs();
        repeat (10) tick();
        checks++;
        if (busy !== 1'b0 || wr_a.size() != 0) begin
            failures++;
            $display("FAIL idle_no_start busy=%b writes=%0d exp 0/0", busy, wr_a.size());
        end
    endtask

    task automatic test_ntsc();
        bit seen;
        start(1'b0);
        run_to_done(2000, seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL ntsc_done timeout got=0 exp=1");
        end
        checks++;
        if (wr_a.size() != 7) begin
            failures++;
            $display("FAIL ntsc_count got=%0d exp=7", wr_a.size());
        end
        for (int i = 0; i < 7 && i < wr_a.size(); i++) begin
            checks++;
            if (wr_a[i] !== exp_a[i] || wr_d[i] !== exp_d(i, 1'b0)) begin
                failures++;
                $display("FAIL ntsc_wr%0d got=%h/%h exp=%h/%h", i, wr_a[i], wr_d[i],
                         exp_a[i], exp_d(i, 1'b0));
            end
        end
        checks++;
        if (lw != 20) begin
            failures++;
            $display("FAIL ntsc_lockwait got=%0d exp=20", lw);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ntsc_busy_done got=%b exp=0", busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ntsc_pulse done=%b busy=%b exp 0/0", done, busy);
        end
        checks++;
        if (zero_bad != 0) begin
            failures++;
            $display("FAIL ntsc_bus_zero got=%0d exp=0", zero_bad);
        end
    endtask

    task automatic test_pal_stall();
        bit seen;
        stall_n = 3;
        start(1'b1);
        run_to_done(2000, seen);
        stall_n = 0;
        checks++;
        if (!seen || wr_a.size() != 7) begin
            failures++;
            $display("FAIL pal_count seen=%b got=%0d exp=1/7", seen, wr_a.size());
        end
        for (int i = 0; i < 7 && i < wr_a.size(); i++) begin
            checks++;
            if (wr_a[i] !== exp_a[i] || wr_d[i] !== exp_d(i, 1'b1)) begin
                failures++;
                $display("FAIL pal_wr%0d got=%h/%h exp=%h/%h", i, wr_a[i], wr_d[i],
                         exp_a[i], exp_d(i, 1'b1));
            end
        end
        checks++;
        if (wcyc != 28) begin
            failures++;
            $display("FAIL pal_write_cycles got=%0d exp=28", wcyc);
        end
        checks++;
        if (stab_bad != 0) begin
            failures++;
            $display("FAIL pal_hold_stable got=%0d exp=0", stab_bad);
        end
        checks++;
        if (lw != 20) begin
            failures++;
            $display("FAIL pal_lockwait got=%0d exp=20", lw);
        end
        tick();
    endtask

    task automatic test_glitch();
        bit seen;
        glitch_at = 10;
        start(1'b0);
        run_to_done(2000, seen);
        glitch_at = -1;
        pll_locked = 1'b1;
        checks++;
        if (!seen || lw != 29) begin
            failures++;
            $display("FAIL glitch_lockwait seen=%b got=%0d exp=29", seen, lw);
        end
        checks++;
        if (wr_a.size() != 7) begin
            failures++;
            $display("FAIL glitch_count got=%0d exp=7", wr_a.size());
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bit seen;
        bit inj;
        seen = 1'b0;
        inj = 1'b0;
        start(1'b0);
        for (int i = 0; i < 2000 && !seen; i++) begin
            tick();
            if (done) begin
                seen = 1'b1;
            end else if (!inj && wr_a.size() == 3) begin
                inj = 1'b1;
                cfg_sel = 1'b1;
                cfg_req = 1'b1;
                tick();
                cfg_req = 1'b0;
                cfg_sel = 1'b0;
            end
        end
        checks++;
        if (!seen || wr_a.size() != 7 || wr_d[5] !== K_NTSC) begin
            failures++;
            $display("FAIL b2b_first seen=%b n=%0d k=%h exp 1/7/%h", seen, wr_a.size(),
                     wr_d[5], K_NTSC);
        end
        clear_logs();
        tick();
        checks++;
        if ({done, busy, mgmt_write} !== 3'b000) begin
            failures++;
            $display("FAIL b2b_idle_gap got=%b exp=000", {done, busy, mgmt_write});
        end
        tick();
        checks++;
        if ({busy, mgmt_write} !== 2'b11) begin
            failures++;
            $display("FAIL b2b_restart got=%b exp=11", {busy, mgmt_write});
        end
        run_to_done(2000, seen);
        checks++;
        if (!seen || wr_a.size() != 7) begin
            failures++;
            $display("FAIL b2b_second seen=%b n=%0d exp 1/7", seen, wr_a.size());
        end
        for (int i = 0; i < 7 && i < wr_a.size(); i++) begin
            checks++;
            if (wr_a[i] !== exp_a[i] || wr_d[i] !== exp_d(i, 1'b1)) begin
                failures++;
                $display("FAIL b2b_wr%0d got=%h/%h exp=%h/%h", i, wr_a[i], wr_d[i],
                         exp_a[i], exp_d(i, 1'b1));
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        int dn;
        start(1'b0);
        for (int i = 0; i < 50 && wr_a.size() < 3; i++) tick();
        mgmt_reset = 1'b1;
        tick();
        checks++;
        if (mgmt_write !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid write=%b busy=%b exp 0/0", mgmt_write, busy);
        end
        tick();
        mgmt_reset = 1'b0;
        n = wr_a.size();
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) dn++;
        end
        checks++;
        if (wr_a.size() != n || dn != 0) begin
            failures++;
            $display("FAIL rst_mid_quiet writes=%0d exp=%0d active=%0d exp=0",
                     wr_a.size(), n, dn);
        end
    endtask

`ifdef PLL_CFG_LOCK_TIMEOUT_EN
    task automatic test_timeout();
        bit seen;
        pll_locked = 1'b0;
        start(1'b0);
        run_to_done(2000, seen);
        checks++;
        if (!seen || lw != 100 || err !== 1'b1) begin
            failures++;
            $display("FAIL timeout seen=%b lw=%0d err=%b exp 1/100/1", seen, lw, err);
        end
        pll_locked = 1'b1;
        tick();
        checks++;
        if (err !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL timeout_sticky err=%b done=%b exp 1/0", err, done);
        end
        start(1'b1);
        run_to_done(2000, seen);
        checks++;
        if (!seen || lw != 20 || err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_keep seen=%b lw=%0d err=%b exp 1/20/1", seen, lw, err);
        end
        mgmt_reset = 1'b1;
        tick();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear got=%b exp=0", err);
        end
        mgmt_reset = 1'b0;
        tick();
    endtask
`else
    task automatic test_no_timeout();
        int dn;
        dn = 0;
        pll_locked = 1'b0;
        start(1'b0);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done || err) dn++;
        end
        checks++;
        if (dn != 0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL wait_forever events=%0d busy=%b exp 0/1", dn, busy);
        end
        mgmt_reset = 1'b1;
        pll_locked = 1'b1;
        tick();
        mgmt_reset = 1'b0;
        tick();
    endtask
`endif

    initial begin
        clear_logs();
        test_reset();
        test_ntsc();
        test_pal_stall();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
`ifdef PLL_CFG_LOCK_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pll_reconfig_ctrl.md
PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

Interface
REQ-001 SHALL have ports: mgmt_clk  in  1  sole clock; mgmt_reset  in  1  synchronous active-high reset.
REQ-002 SHALL have ports: cfg_req  in  1  one-cycle request pulse; cfg_sel  in  1  0=NTSC, 1=PAL, sampled with cfg_req.
REQ-003 SHALL have ports: mgmt_address  out  6; mgmt_write  out  1; mgmt_writedata  out  32; mgmt_waitrequest  in  1.
REQ-004 SHALL have ports: pll_locked  in  1  asynchronous PLL lock; busy  out  1; done  out  1  one-cycle completion pulse; err  out  1  sticky lock timeout.
REQ-005 SHALL have parameter LOCK_STABLE, default 16, meaning consecutive synchronized-locked cycles required.
REQ-006 SHALL have parameter LOCK_TIMEOUT, default 1048576, meaning lock-wait cycle limit.

Function
REQ-007 SHALL implement states IDLE, WRITE, LOCKWAIT and DONE.
REQ-008 SHALL, in IDLE, on cfg_req=1 latch cfg_sel, set busy=1, zero the step index and enter WRITE on the next cycle.
REQ-009 SHALL, in WRITE, issue seven writes in order (address, data): 0x00,0x00000000 (waitrequest mode); 0x04,0x00000404 (M); 0x03,0x00010000 (N bypass); 0x05,0x00000404 (C0); 0x05,0x00040202 (C1); 0x07,K; 0x02,0x00000001 (start).
REQ-010 SHALL set K=2532450157 for NTSC (VCO 429.4816 MHz) and K=2537930535 for PAL.
REQ-011 SHALL hold mgmt_write=1 with address and data stable while mgmt_waitrequest=1.
REQ-012 SHALL count a write as accepted only on a cycle with mgmt_write=1 and mgmt_waitrequest=0, and SHALL present the next write on the following cycle with no idle gap.
REQ-013 SHALL, on acceptance of the start write, drop mgmt_write, clear the lock counters and enter LOCKWAIT.
REQ-014 SHALL pass pll_locked through a 2-flop synchronizer; all lock decisions SHALL use the synchronized value.
REQ-015 SHALL, in LOCKWAIT, ignore lock for the first 4 cycles, then count consecutive synchronized-high cycles and reset that count to 0 on any low cycle.
REQ-016 SHALL enter DONE when the consecutive-high count reaches LOCK_STABLE.
REQ-017 SHALL, in DONE, assert done=1 for exactly one cycle, deassert busy in that same cycle and return to IDLE.
REQ-018 SHALL register a cfg_req received while busy=1 (including the DONE cycle) as pending, keeping the most recent cfg_sel.
REQ-019 SHALL start a pending request from IDLE on the cycle after DONE, with busy remaining 0 for exactly that one IDLE cycle.
REQ-020 SHALL keep busy=1 from the cycle after an accepted cfg_req until the DONE cycle.
REQ-021 SHALL hold mgmt_address and mgmt_writedata at 0 whenever mgmt_write=0.

Reset
REQ-022 SHALL, while mgmt_reset=1 (sampled on mgmt_clk), force state IDLE and clear mgmt_write, mgmt_address, mgmt_writedata, busy, done, err, the pending flag, all counters and the synchronizer flops.
REQ-023 SHALL, on reset mid-operation, drop mgmt_write in the first reset cycle and leave the remaining sequence unissued.
REQ-024 SHALL NOT start any configuration after reset until a cfg_req arrives.

Configuration
REQ-025 SHALL, with PLL_CFG_LOCK_TIMEOUT_EN defined, count LOCKWAIT cycles.
REQ-026 SHALL, on reaching LOCK_TIMEOUT, set err=1 (sticky until reset), pulse done and return to IDLE.
REQ-027 SHALL clear err only on mgmt_reset.
REQ-028 SHALL, with PLL_CFG_LOCK_TIMEOUT_EN undefined, wait in LOCKWAIT indefinitely, hold err at constant 0 and omit the timeout counter.

Verification
REQ-029 SHALL cover: cfg_req with cfg_sel=0, waitrequest=0, locked high -> exactly 7 writes, 6th data 2532450157, then done after 4+16+sync cycles.
REQ-030 SHALL cover: cfg_sel=1 with waitrequest high 3 cycles on each write -> address/data stable throughout, 6th data 2537930535, 7 writes total.
REQ-031 SHALL cover: locked glitching low at LOCKWAIT cycle 10 -> stable count restarts and done is delayed accordingly.
REQ-032 SHALL cover: cfg_req(sel=1) during the 3rd write of an NTSC run -> done pulse, then one IDLE cycle, then a second sequence with PAL K.
REQ-033 SHALL cover: mgmt_reset asserted mid-WRITE -> mgmt_write=0 and busy=0 on the next edge, and no further writes issued.
REQ-034 SHALL cover, with PLL_CFG_LOCK_TIMEOUT_EN defined and LOCK_TIMEOUT=100, locked held low -> err=1 and done pulse at cycle 100 of LOCKWAIT.
